dmem_wait_ctrl: RTL

DMEM_WAIT_CTRL -- requirements
Module: dmem_wait_ctrl

---
 rtl/dmem_wait_ctrl_pkg.sv | 7 +
 rtl/sp_ram_bytewr.sv | 27 ++
 rtl/dmem_wait_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dmem_wait_ctrl_pkg.sv
// dmem_wait_ctrl_pkg: state type and latency bounds shared by the
// data-memory wait-state controller and its testbench.
package dmem_wait_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
endpackage

// File: rtl/sp_ram_bytewr.sv
// sp_ram_bytewr: single-port synchronous word array with per-byte write
// enables and a registered read port that holds its value between reads.
module sp_ram_bytewr #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic                    clk,
    input  logic [AW-1:0]           addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    we_i,
    input  logic                    re_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (re_i) rdata_q <= mem_q[addr_i];
        if (we_i)
            for (int i = 0; i < DATA_WIDTH/8; i++)
                if (wstrb_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: fixed-latency data-memory controller; accepts one load or
// store at a time, waits LATENCY cycles, then issues a one-cycle ready pulse.
module dmem_wait_ctrl
    import dmem_wait_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dmem_wstrb_i,
    input  logic                    dmem_write_i,
    input  logic                    dmem_read_i,
    output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
    output logic                    dmem_ready_o,
    output logic                    busy_o,
    output logic                    err_o
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = ADDR_WIDTH - LSB;
    localparam int RAW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]    CNT_INIT  = 4'(LATENCY - 1);
    localparam logic [IW-1:0] DEPTH_IDX = IW'(DEPTH_WORDS);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("dmem_wait_ctrl: LATENCY %0d outside %0d..%0d", LATENCY, LATENCY_MIN, LATENCY_MAX);
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("dmem_wait_ctrl: DATA_WIDTH %0d not a multiple of 8", DATA_WIDTH);
    end

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           wstrb_q, wstrb_d;
    logic                    write_q, write_d;
    logic                    err_q, err_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    req, in_range, ram_we, ram_re;
    logic [IW-1:0]           idx;
    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic                    unused_addr;

    assign req         = dmem_read_i | dmem_write_i;
    assign idx         = addr_q[ADDR_WIDTH-1:LSB];
    assign in_range    = idx < DEPTH_IDX;
    assign unused_addr = ^addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            write_q    <= write_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        write_d    = write_q;
        err_d      = err_q;
        rd_valid_d = rd_valid_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                addr_d  = dmem_addr_i;
                wdata_d = dmem_wdata_i;
                wstrb_d = dmem_wstrb_i;
                write_d = dmem_write_i & ~dmem_read_i;
                cnt_d   = CNT_INIT;
                err_d   = err_q | (dmem_write_i & dmem_read_i);
                state_d = WAIT;
            end
            WAIT: begin
                err_d = err_q | req;
                if (cnt_q == '0) begin
                    ram_we  = write_q & in_range;
                    ram_re  = ~write_q & in_range;
                    // an out-of-range load reads as zero until the next load
                    rd_valid_d = write_q ? rd_valid_q : in_range;
                    err_d   = err_q | req | ~in_range;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                err_d   = err_q | req;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    sp_ram_bytewr #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (RAW)
    ) u_ram (
        .clk    (clk),
        .addr_i (idx[RAW-1:0]),
        .wdata_i(wdata_q),
        .wstrb_i(wstrb_q),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .rdata_o(ram_rdata)
    );

    assign dmem_ready_o = state_q == RESP;
    assign busy_o       = state_q != IDLE;
    assign err_o        = err_q;
    assign dmem_rdata_o = rd_valid_q ? ram_rdata : '0;
endmodule
